// File: rtl/apb_irq_ctrl.sv
// apb_irq_ctrl: fixed-priority interrupt controller with APB claim/complete interface
module apb_irq_ctrl #(
    parameter int NSRC = 15,
    parameter int IDW  = $clog2(NSRC + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     paddr,
    input  logic            psel,
    input  logic            penable,
    input  logic            pwrite,
    input  logic [31:0]     pwdata,
    output logic [31:0]     prdata,
    output logic            pready,
    output logic            pslverr,
    input  logic [NSRC-1:0] irq_src,
    output logic            irq_o
);
    logic [NSRC-1:0] pending, enable, trigger, inservice, src_q;
    logic [NSRC-1:0] eligible, set_v, clm, cmp;
    logic [IDW-1:0]  claim_id, claim_id_q;
    logic            access, rd, wr;
    logic [2:0]      addr;
    logic            unused_addr;

    assign access      = psel & penable;
    assign rd          = access & ~pwrite;
    assign wr          = access & pwrite;
    assign addr        = paddr[4:2];
    assign unused_addr = ^{paddr[31:5], paddr[1:0]};
    assign pready      = 1'b1;
    assign pslverr     = access & (addr > 3'd4);
    assign eligible    = pending & enable & ~inservice;
    // an edge source only pends when the previous sample was low
    assign set_v       = irq_src & ~inservice & ~(trigger & src_q);
    assign prdata      = !rd          ? '0 :
                         addr == 3'd0 ? 32'(pending) :
                         addr == 3'd1 ? 32'(enable) :
                         addr == 3'd2 ? 32'(trigger) :
                         addr == 3'd3 ? 32'(claim_id_q) : '0;

    // lowest eligible index wins; scanning downward leaves the lowest match last
    always_comb begin
        claim_id = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (eligible[i]) claim_id = IDW'(i + 1);
    end

    // per-source claim and complete strobes decoded from the current access
    always_comb begin
        clm = '0;
        cmp = '0;
        for (int i = 0; i < NSRC; i++) begin
            clm[i] = rd && addr == 3'd3 && claim_id_q == IDW'(i + 1);
            cmp[i] = wr && addr == 3'd4 && pwdata == 32'(i + 1);
        end
    end

    // state update; a claim clear overrides a same-cycle pend
    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            enable     <= '0;
            trigger    <= '0;
            inservice  <= '0;
            src_q      <= '0;
            claim_id_q <= '0;
            irq_o      <= 1'b0;
        end else begin
            src_q      <= irq_src;
            pending    <= (pending | set_v) & ~clm;
            inservice  <= (inservice | clm) & ~cmp;
            claim_id_q <= claim_id;
            irq_o      <= |eligible;
            if (wr && addr == 3'd1) enable  <= pwdata[NSRC-1:0];
            if (wr && addr == 3'd2) trigger <= pwdata[NSRC-1:0];
        end
    end
endmodule
